cp0_reg: RTL and testbench
==========================

Name: cp0_reg

Overview:
- Coprocessor-0 register file and exception commit point of the 5-stage MIPS pipeline.
- Consumes the write-back stage outputs: mtc0 write enable, CP0 address, data, exception vector and branch-delay flag.
- Maintains Count/Compare/Status/Cause/EPC/BadVAddr, serves mfc0 reads to EX, raises the timer interrupt, and drives flush/new-PC to the pipeline controller.

Parameters:
EXC_ENTRY, 32'hBFC0_0380, exception handler vector.
STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (all state cleared while low)
i_mtc0_we  in  1  CP0 write enable from MEM/WB
i_c0_waddr  in  5  CP0 write address
i_c0_wdata  in  32  CP0 write data
i_c0_raddr  in  5  mfc0 read address from EX
i_except  in  32  one-hot exception flags of committing instruction
i_bd  in  1  committing instruction is in a delay slot
i_pc  in  32  PC of committing instruction
i_bad_vaddr  in  32  faulting address for AdEL/AdES
i_int  in  6  external hardware interrupts, level
o_rdata  out  32  mfc0 read data
o_status, o_cause, o_epc  out  32 each  live register values, for forwarding
o_timer_int  out  1  Count==Compare pending
o_flush  out  1  flush pipeline this cycle
o_new_pc  out  32  redirect target, valid when o_flush=1

Behaviour:
- Reset (reset=0, async) values:
  - Count, Compare, Cause, EPC, BadVAddr = 0; Status = STATUS_RST.
  - Count phase bit = 0; o_timer_int = 0; o_flush = 0; o_new_pc = 0.
- Register addresses: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[1:0] only.
  - All other bits are read-only.
- Count timing:
  - Count increments once every 2 cycles, driven by a phase toggle, and wraps 0xFFFF_FFFF->0.
  - mtc0 to Count loads the data and clears the phase; the write wins over the increment.
- Timer interrupt:
  - o_timer_int sets on the clock edge where Count==Compare and Compare!=0.
  - Cleared only by an mtc0 to Compare; a clear in the same cycle as a match leaves it clear.
- Interrupt pending:
  - Cause.IP[7:2] is registered each cycle from {i_int[5]|o_timer_int, i_int[4:0]}.
  - Pending interrupt = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Exception priority, combinational same cycle:
  - Order: interrupt > AdEL-fetch > RI > Ov > Syscall > Break > AdEL-load > AdES > ERET.
  - ExcCodes in the same order: 0, 4, 10, 12, 8, 9, 4, 5; ERET takes no code.
- Exception taken (not ERET):
  - o_flush=1, o_new_pc=EXC_ENTRY.
  - Next edge: ExcCode updated, Status.EXL<=1.
  - If EXL was 0: EPC <= i_bd ? i_pc-4 : i_pc and Cause.BD <= i_bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - BadVAddr <= i_pc for AdEL-fetch, <= i_bad_vaddr for AdEL-load and AdES.
- ERET: o_flush=1, o_new_pc=EPC; next edge Status.EXL<=0.
- Simultaneous events:
  - An exception/ERET suppresses the mtc0 of the same instruction.
  - The hardware updates to Count and Cause.IP still occur.
- mfc0 read:
  - Combinational.
  - If i_mtc0_we and i_c0_waddr==i_c0_raddr, return the write-merged value (bypass).
  - Unmapped addresses read 0.
- Reset mid-exception: state returns to reset values immediately; o_flush drops.

Optional Feature:
- Macro: CP0_CFG_REGS_EN.
- Defined: adds read-only PRId (addr 15) = 32'h0001_8003 and Config (addr 16) = 32'h8000_0483; writes to them are ignored.
- Undefined: addresses 15/16 behave as unmapped and read 0.

Decomposition:
- Shared package cp0_pkg holds:
  - CP0 register address constants.
  - i_except bit positions: ADEL_IF=13, RI=10, OV=11, SYS=8, BRK=9, ADEL_LD=14, ADES=15, ERET=12.
  - ExcCode constants and Status/Cause field indices.
- One natural sub-module: cp0_exc_arbiter, the combinational priority encoder that produces exc_valid, exc_code, is_eret and new_pc.

Test Plan:
- Reset release: check reset values, then write Compare=4, Count=0 -> o_timer_int=1 on the edge where Count reaches 4 (about 8 cycles later); a later mtc0 Compare clears it.
- Syscall: i_except[8]=1, i_pc=0xBFC0_0100, i_bd=0 -> o_flush=1, o_new_pc=0xBFC0_0380, EPC=0xBFC0_0100, ExcCode=8, EXL=1.
- Delay slot: i_bd=1, i_pc=0x8000_0024 with Ov -> EPC=0x8000_0020, Cause.BD=1, ExcCode=12.
- Nested exception with EXL=1: EPC stays unchanged; a subsequent ERET gives o_new_pc=EPC and EXL=0.
- Interrupt: Status=0x0000_0401, i_int[0]=1 -> interrupt taken with ExcCode 0; with EXL=1 it is masked and no flush occurs.
- mfc0 bypass: mtc0 Status 0x0000_FF01 with raddr 12 in the same cycle -> o_rdata=0x0040_FF01; mtc0 together with Break -> Status unchanged.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception flag positions,
// ExcCodes, Status/Cause field indices and the masked-write helper.
package cp0_pkg;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
`ifdef CP0_CFG_REGS_EN
  localparam logic [4:0]  ADDR_PRID    = 5'd15;
  localparam logic [4:0]  ADDR_CONFIG  = 5'd16;
  localparam logic [31:0] PRID_VAL     = 32'h0001_8003;
  localparam logic [31:0] CONFIG_VAL   = 32'h8000_0483;
`endif

  localparam int EXC_SYS     = 8;
  localparam int EXC_BRK     = 9;
  localparam int EXC_RI      = 10;
  localparam int EXC_OV      = 11;
  localparam int EXC_ERET    = 12;
  localparam int EXC_ADEL_IF = 13;
  localparam int EXC_ADEL_LD = 14;
  localparam int EXC_ADES    = 15;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_IM_HI  = 15;
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                         input logic [31:0] new_val,
                                         input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// Write-back / mfc0 / redirect signal bundle between the pipeline and CP0.
interface cp0_reg_if;
  logic        i_mtc0_we;
  logic [4:0]  i_c0_waddr;
  logic [31:0] i_c0_wdata;
  logic [4:0]  i_c0_raddr;
  logic [31:0] i_except;
  logic        i_bd;
  logic [31:0] i_pc;
  logic [31:0] i_bad_vaddr;
  logic [5:0]  i_int;
  logic [31:0] o_rdata;
  logic [31:0] o_status;
  logic [31:0] o_cause;
  logic [31:0] o_epc;
  logic        o_timer_int;
  logic        o_flush;
  logic [31:0] o_new_pc;

  modport master (
    output i_mtc0_we, i_c0_waddr, i_c0_wdata, i_c0_raddr, i_except,
           i_bd, i_pc, i_bad_vaddr, i_int,
    input  o_rdata, o_status, o_cause, o_epc, o_timer_int, o_flush, o_new_pc
  );

  modport slave (
    input  i_mtc0_we, i_c0_waddr, i_c0_wdata, i_c0_raddr, i_except,
           i_bd, i_pc, i_bad_vaddr, i_int,
    output o_rdata, o_status, o_cause, o_epc, o_timer_int, o_flush, o_new_pc
  );
endinterface

// File: rtl/cp0_exc_arbiter.sv
// Combinational exception priority encoder: picks the winning event of the
// committing instruction and the redirect target.
module cp0_exc_arbiter
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
  input  logic        int_pending,
  input  logic [31:0] except,
  input  logic [31:0] epc,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        is_eret,
  output logic [31:0] new_pc,
  output logic        badv_from_pc,
  output logic        badv_from_addr
);

  logic unused_s;
  assign unused_s = ^{except[31:16], except[7:0]};

  // Highest-priority event wins; ERET only when nothing else is raised.
  always_comb begin
    exc_valid      = 1'b0;
    exc_code       = CODE_INT;
    is_eret        = 1'b0;
    badv_from_pc   = 1'b0;
    badv_from_addr = 1'b0;
    if (int_pending) begin
      exc_valid = 1'b1;
    end else if (except[EXC_ADEL_IF]) begin
      exc_valid    = 1'b1;
      exc_code     = CODE_ADEL;
      badv_from_pc = 1'b1;
    end else if (except[EXC_RI]) begin
      exc_valid = 1'b1;
      exc_code  = CODE_RI;
    end else if (except[EXC_OV]) begin
      exc_valid = 1'b1;
      exc_code  = CODE_OV;
    end else if (except[EXC_SYS]) begin
      exc_valid = 1'b1;
      exc_code  = CODE_SYS;
    end else if (except[EXC_BRK]) begin
      exc_valid = 1'b1;
      exc_code  = CODE_BP;
    end else if (except[EXC_ADEL_LD]) begin
      exc_valid      = 1'b1;
      exc_code       = CODE_ADEL;
      badv_from_addr = 1'b1;
    end else if (except[EXC_ADES]) begin
      exc_valid      = 1'b1;
      exc_code       = CODE_ADES;
      badv_from_addr = 1'b1;
    end else if (except[EXC_ERET]) begin
      is_eret = 1'b1;
    end else begin
      is_eret = 1'b0;
    end

    if (exc_valid) begin
      new_pc = EXC_ENTRY;
    end else if (is_eret) begin
      new_pc = epc;
    end else begin
      new_pc = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file and exception commit point of the 5-stage pipeline.
// Define CP0_CFG_REGS_EN to add the read-only PRId/Config registers.
module cp0_reg
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input logic      clk,
  input logic      reset,
  cp0_reg_if.slave bus
);

  logic [31:0] count_r, compare_r, status_r, cause_r, epc_r, badvaddr_r;
  logic        phase_r, timer_int_r;
  logic        int_pending_s, exc_valid_s, is_eret_s, wr_en_s;
  logic        badv_pc_s, badv_addr_s;
  logic [4:0]  exc_code_s;
  logic [31:0] new_pc_s, read_s, merged_s;

  assign int_pending_s = status_r[ST_IE] & ~status_r[ST_EXL] &
                         (|(cause_r[CA_IP_HI:CA_IP_LO] & status_r[ST_IM_HI:ST_IM_LO]));

  cp0_exc_arbiter #(.EXC_ENTRY(EXC_ENTRY)) u_arb (
    .int_pending   (int_pending_s),
    .except        (bus.i_except),
    .epc           (epc_r),
    .exc_valid     (exc_valid_s),
    .exc_code      (exc_code_s),
    .is_eret       (is_eret_s),
    .new_pc        (new_pc_s),
    .badv_from_pc  (badv_pc_s),
    .badv_from_addr(badv_addr_s)
  );

  // A faulting or returning instruction never gets to write CP0.
  assign wr_en_s = bus.i_mtc0_we & ~exc_valid_s & ~is_eret_s;

  // Register contents as seen by mfc0 without bypass.
  always_comb begin
    read_s = 32'h0000_0000;
    case (bus.i_c0_raddr)
      ADDR_BADVADDR: read_s = badvaddr_r;
      ADDR_COUNT:    read_s = count_r;
      ADDR_COMPARE:  read_s = compare_r;
      ADDR_STATUS:   read_s = status_r;
      ADDR_CAUSE:    read_s = cause_r;
      ADDR_EPC:      read_s = epc_r;
`ifdef CP0_CFG_REGS_EN
      ADDR_PRID:     read_s = PRID_VAL;
      ADDR_CONFIG:   read_s = CONFIG_VAL;
`endif
      default:       read_s = 32'h0000_0000;
    endcase
  end

  // Value the addressed register takes once the pending mtc0 is applied.
  always_comb begin
    merged_s = 32'h0000_0000;
    case (bus.i_c0_waddr)
      ADDR_BADVADDR: merged_s = badvaddr_r;
      ADDR_COUNT:    merged_s = bus.i_c0_wdata;
      ADDR_COMPARE:  merged_s = bus.i_c0_wdata;
      ADDR_STATUS:   merged_s = wmerge(status_r, bus.i_c0_wdata, STATUS_WMASK);
      ADDR_CAUSE:    merged_s = wmerge(cause_r, bus.i_c0_wdata, CAUSE_WMASK);
      ADDR_EPC:      merged_s = bus.i_c0_wdata;
`ifdef CP0_CFG_REGS_EN
      ADDR_PRID:     merged_s = PRID_VAL;
      ADDR_CONFIG:   merged_s = CONFIG_VAL;
`endif
      default:       merged_s = 32'h0000_0000;
    endcase
  end

  assign bus.o_rdata     = (bus.i_mtc0_we && (bus.i_c0_waddr == bus.i_c0_raddr)) ? merged_s : read_s;
  assign bus.o_status    = status_r;
  assign bus.o_cause     = cause_r;
  assign bus.o_epc       = epc_r;
  assign bus.o_timer_int = timer_int_r;
  assign bus.o_flush     = reset & (exc_valid_s | is_eret_s);
  assign bus.o_new_pc    = reset ? new_pc_s : 32'h0000_0000;

  // CP0 state: timer, hardware interrupt sampling, mtc0 writes, exception commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r     <= 32'h0000_0000;
      compare_r   <= 32'h0000_0000;
      status_r    <= STATUS_RST;
      cause_r     <= 32'h0000_0000;
      epc_r       <= 32'h0000_0000;
      badvaddr_r  <= 32'h0000_0000;
      phase_r     <= 1'b0;
      timer_int_r <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
      if (wr_en_s && (bus.i_c0_waddr == ADDR_COUNT)) begin
        count_r <= bus.i_c0_wdata;
        phase_r <= 1'b0;
      end else if (phase_r) begin
        count_r <= count_r + 32'd1;
      end

      if (wr_en_s && (bus.i_c0_waddr == ADDR_COMPARE)) begin
        compare_r   <= bus.i_c0_wdata;
        timer_int_r <= 1'b0;
      end else if ((count_r == compare_r) && (compare_r != 32'h0000_0000)) begin
        timer_int_r <= 1'b1;
      end

      cause_r[CA_IP_HI:CA_IP_LO+2] <= {bus.i_int[5] | timer_int_r, bus.i_int[4:0]};

      if (wr_en_s && (bus.i_c0_waddr == ADDR_STATUS)) begin
        status_r <= wmerge(status_r, bus.i_c0_wdata, STATUS_WMASK);
      end
      if (wr_en_s && (bus.i_c0_waddr == ADDR_CAUSE)) begin
        cause_r[CA_IP_LO+1:CA_IP_LO] <= bus.i_c0_wdata[CA_IP_LO+1:CA_IP_LO];
      end
      if (wr_en_s && (bus.i_c0_waddr == ADDR_EPC)) begin
        epc_r <= bus.i_c0_wdata;
      end

      if (exc_valid_s) begin
        cause_r[CA_EXC_HI:CA_EXC_LO] <= exc_code_s;
        status_r[ST_EXL]             <= 1'b1;
        // A nested exception keeps the original return point.
        if (!status_r[ST_EXL]) begin
          epc_r          <= bus.i_bd ? (bus.i_pc - 32'd4) : bus.i_pc;
          cause_r[CA_BD] <= bus.i_bd;
        end
        if (badv_pc_s) begin
          badvaddr_r <= bus.i_pc;
        end else if (badv_addr_s) begin
          badvaddr_r <= bus.i_bad_vaddr;
        end
      end else if (is_eret_s) begin
        status_r[ST_EXL] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_cp0_reg;

  localparam logic [31:0] EXC_ENTRY  = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  logic clk;
  logic reset;
  cp0_reg_if bus();

  cp0_reg #(.EXC_ENTRY(EXC_ENTRY), .STATUS_RST(STATUS_RST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Count is base + (edges since last load) / 2.
  logic [31:0] m_base, m_compare, m_status, m_cause, m_epc, m_badv;
  int unsigned m_cyc;
  logic        m_timer;

  int unsigned pri_bit [7] = '{13, 10, 11, 8, 9, 14, 15};
  logic [4:0]  pri_code[7] = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};

  task automatic model_reset();
    m_base = 32'h0; m_cyc = 0; m_compare = 32'h0; m_status = STATUS_RST;
    m_cause = 32'h0; m_epc = 32'h0; m_badv = 32'h0; m_timer = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic [31:0] cnt);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return cnt;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
`ifdef CP0_CFG_REGS_EN
      5'd15:   return 32'h0001_8003;
      5'd16:   return 32'h8000_0483;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_after_write(input logic [4:0] a, input logic [31:0] w,
                                                    input logic [31:0] cnt);
    logic [31:0] v;
    v = model_read(a, cnt);
    case (a)
      5'd9, 5'd11, 5'd14: v = w;
      5'd12: begin v[15:8] = w[15:8]; v[1] = w[1]; v[0] = w[0]; end
      5'd13: v[9:8] = w[9:8];
      default: v = model_read(a, cnt);
    endcase
    return v;
  endfunction

  // Compare DUT against the model on every falling edge, then advance the model.
  always @(negedge clk) begin : cmp_p
    logic [31:0] cnt, exp_pc, exp_rd, mrg;
    logic        pend, exc, eret, bpc, badr, wr, nt;
    logic [4:0]  code;
    if (!reset) begin
      model_reset();
      chk("rst_flush",  {31'd0, bus.o_flush}, 32'd0);
      chk("rst_newpc",  bus.o_new_pc, 32'd0);
      chk("rst_status", bus.o_status, STATUS_RST);
      chk("rst_cause",  bus.o_cause, 32'd0);
      chk("rst_epc",    bus.o_epc, 32'd0);
      chk("rst_timer",  {31'd0, bus.o_timer_int}, 32'd0);
    end else begin
      cnt  = m_base + 32'(m_cyc >> 1);
      pend = m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
      exc = pend; code = 5'd0; bpc = 1'b0; badr = 1'b0; eret = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (!exc && bus.i_except[pri_bit[k]]) begin
          exc = 1'b1; code = pri_code[k]; bpc = (k == 0); badr = (k >= 5);
        end
      end
      if (!exc) eret = bus.i_except[12];
      exp_pc = exc ? EXC_ENTRY : (eret ? m_epc : 32'h0);
      mrg    = model_after_write(bus.i_c0_waddr, bus.i_c0_wdata, cnt);
      exp_rd = (bus.i_mtc0_we && bus.i_c0_waddr == bus.i_c0_raddr) ? mrg : model_read(bus.i_c0_raddr, cnt);

      chk("flush",  {31'd0, bus.o_flush}, {31'd0, exc | eret});
      chk("new_pc", bus.o_new_pc, exp_pc);
      chk("rdata",  bus.o_rdata, exp_rd);
      chk("status", bus.o_status, m_status);
      chk("cause",  bus.o_cause, m_cause);
      chk("epc",    bus.o_epc, m_epc);
      chk("timer",  {31'd0, bus.o_timer_int}, {31'd0, m_timer});

      wr = bus.i_mtc0_we && !exc && !eret;
      nt = m_timer;
      if (cnt == m_compare && m_compare != 32'h0) nt = 1'b1;
      if (wr && bus.i_c0_waddr == 5'd11) begin m_compare = bus.i_c0_wdata; nt = 1'b0; end
      if (wr && bus.i_c0_waddr == 5'd9) begin m_base = bus.i_c0_wdata; m_cyc = 0; end
      else m_cyc++;
      m_cause[15:10] = {bus.i_int[5] | m_timer, bus.i_int[4:0]};
      m_timer = nt;
      if (wr && (bus.i_c0_waddr == 5'd12 || bus.i_c0_waddr == 5'd13)) begin
        if (bus.i_c0_waddr == 5'd12) m_status = mrg;
        else m_cause[9:8] = bus.i_c0_wdata[9:8];
      end
      if (wr && bus.i_c0_waddr == 5'd14) m_epc = bus.i_c0_wdata;
      if (exc) begin
        m_cause[6:2] = code;
        if (!m_status[1]) begin
          m_epc = bus.i_bd ? bus.i_pc - 32'd4 : bus.i_pc;
          m_cause[31] = bus.i_bd;
        end
        m_status[1] = 1'b1;
        if (bpc) m_badv = bus.i_pc;
        else if (badr) m_badv = bus.i_bad_vaddr;
      end else if (eret) begin
        m_status[1] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.i_mtc0_we = 1'b0; bus.i_c0_waddr = 5'd0; bus.i_c0_wdata = 32'h0;
    bus.i_c0_raddr = 5'd0; bus.i_except = 32'h0; bus.i_bd = 1'b0;
    bus.i_pc = 32'h0; bus.i_bad_vaddr = 32'h0; bus.i_int = 6'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.i_mtc0_we = 1'b1; bus.i_c0_waddr = a; bus.i_c0_wdata = d;
  endtask

  logic [4:0] addr_list[10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd3};

  initial begin : drv
    int k;
    int r;
    reset = 1'b0;
    idle();
    repeat (3) tick();
    chk("lit_rst_status", bus.o_status, 32'h0040_0000);
    reset = 1'b1;
    tick();

    // Timer: Compare=4, Count=0, interrupt 9 edges after the Count load.
    mtc0(5'd11, 32'd4); tick();
    mtc0(5'd9, 32'd0);  tick();
    idle();
    k = 0;
    while (!bus.o_timer_int && k < 20) begin tick(); k++; end
    chk("lit_timer_latency", 32'(k), 32'd9);
    mtc0(5'd11, 32'd0); tick(); idle();
    chk("lit_timer_clear", {31'd0, bus.o_timer_int}, 32'd0);

    // Syscall outside a delay slot.
    bus.i_except = 32'h0000_0100; bus.i_pc = 32'hBFC0_0100; #1;
    chk("lit_sys_flush", {31'd0, bus.o_flush}, 32'd1);
    chk("lit_sys_newpc", bus.o_new_pc, 32'hBFC0_0380);
    tick(); idle();
    chk("lit_sys_epc",  bus.o_epc, 32'hBFC0_0100);
    chk("lit_sys_code", {27'd0, bus.o_cause[6:2]}, 32'd8);
    chk("lit_sys_exl",  {31'd0, bus.o_status[1]}, 32'd1);
    bus.i_except = 32'h0000_1000; #1;
    chk("lit_eret_newpc", bus.o_new_pc, 32'hBFC0_0100);
    tick(); idle();
    chk("lit_eret_exl", {31'd0, bus.o_status[1]}, 32'd0);

    // Overflow in a delay slot, then a nested Break.
    bus.i_except = 32'h0000_0800; bus.i_bd = 1'b1; bus.i_pc = 32'h8000_0024;
    tick(); idle();
    chk("lit_ds_epc",  bus.o_epc, 32'h8000_0020);
    chk("lit_ds_bd",   {31'd0, bus.o_cause[31]}, 32'd1);
    chk("lit_ds_code", {27'd0, bus.o_cause[6:2]}, 32'd12);
    bus.i_except = 32'h0000_0200; bus.i_pc = 32'h1234_5678;
    tick(); idle();
    chk("lit_nest_epc",  bus.o_epc, 32'h8000_0020);
    chk("lit_nest_code", {27'd0, bus.o_cause[6:2]}, 32'd9);
    bus.i_except = 32'h0000_1000; #1;
    chk("lit_nest_eret_pc", bus.o_new_pc, 32'h8000_0020);
    tick(); idle();
    chk("lit_nest_eret_exl", {31'd0, bus.o_status[1]}, 32'd0);

    // External interrupt 0 taken, then masked by EXL.
    mtc0(5'd12, 32'h0000_0401); tick(); idle();
    chk("lit_int_status", bus.o_status, 32'h0040_0401);
    bus.i_int = 6'd1; bus.i_pc = 32'h8000_1000;
    tick(); #1;
    chk("lit_int_flush", {31'd0, bus.o_flush}, 32'd1);
    tick();
    chk("lit_int_code", {27'd0, bus.o_cause[6:2]}, 32'd0);
    chk("lit_int_masked", {31'd0, bus.o_flush}, 32'd0);
    bus.i_int = 6'd0; tick();
    bus.i_except = 32'h0000_1000; tick(); idle();

    // mfc0 bypass, then an mtc0 suppressed by Break.
    mtc0(5'd12, 32'h0000_FF01); bus.i_c0_raddr = 5'd12; #1;
    chk("lit_bypass", bus.o_rdata, 32'h0040_FF01);
    tick(); idle();
    mtc0(5'd12, 32'h0000_0000); bus.i_except = 32'h0000_0200;
    tick(); idle();
    chk("lit_suppress", bus.o_status, 32'h0040_FF03);
    bus.i_except = 32'h0000_1000; tick(); idle();

    // Randomized traffic with one asynchronous reset pulse.
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) reset = 1'b0;
      if (it == 1503) reset = 1'b1;
      idle();
      if ($urandom_range(0, 3) == 0) begin
        bus.i_mtc0_we  = 1'b1;
        bus.i_c0_waddr = addr_list[$urandom_range(0, 9)];
        bus.i_c0_wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
      end
      bus.i_c0_raddr = $urandom_range(0, 1) ? bus.i_c0_waddr : addr_list[$urandom_range(0, 9)];
      r = $urandom_range(0, 11);
      if (r == 7)       bus.i_except = 32'd1 << pri_bit[$urandom_range(0, 6)];
      else if (r == 8)  bus.i_except = {16'h0, 8'($urandom), 8'h0};
      else if (r == 9)  bus.i_except = 32'h0000_1000;
      else              bus.i_except = 32'h0;
      bus.i_bd        = 1'($urandom);
      bus.i_pc        = $urandom & 32'hFFFF_FFFC;
      bus.i_bad_vaddr = $urandom;
      bus.i_int       = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
